// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver, oversampled by a shared baud tick.
// Recovers start/8 data (LSB first)/stop frames from rxd and presents the
// byte with a ready flag and sticky framing/overrun error flags.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | line idle, waiting for rxd_s to fall
// ST_START | counting to mid start bit to confirm it is not a glitch
// ST_DATA  | sampling 8 data bits at their midpoints
// ST_STOP  | sampling mid stop bit; load byte or flag framing error
// ST_BREAK | bad stop bit seen; wait for the line to return high

module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_enable,
    input  logic       rxd,
    input  logic       rd_ack,
    output logic [7:0] data,
    output logic       rda,
    output logic       framing_err,
    output logic       overrun_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             rxd_m;
    logic             rxd_s;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // Frame FSM with registered outputs; later assignments give set priority over rd_ack clears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= 8'h00;
            data        <= 8'h00;
            rda         <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (rd_ack) begin
                rda         <= 1'b0;
                framing_err <= 1'b0;
                overrun_err <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end

                ST_START: begin
                    if (baud_enable) begin
                        if (cnt == HALF_M1) begin
                            cnt <= '0;
                            if (!rxd_s) begin
                                state   <= ST_DATA;
                                bit_idx <= '0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                ST_DATA: begin
                    if (baud_enable) begin
                        if (cnt == FULL_M1) begin
                            shift   <= {rxd_s, shift[7:1]};
                            cnt     <= '0;
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= ST_STOP;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                ST_STOP: begin
                    if (baud_enable) begin
                        if (cnt == FULL_M1) begin
                            cnt <= '0;
                            if (rxd_s) begin
                                data  <= shift;
                                rda   <= 1'b1;
                                state <= ST_IDLE;
                                if (rda && !rd_ack) begin
                                    overrun_err <= 1'b1;
                                end
                            end else begin
                                framing_err <= 1'b1;
                                state       <= ST_BREAK;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                ST_BREAK: begin
                    if (baud_enable && rxd_s) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: OVERSAMPLE=16, baud tick every clk.
module tb_uart_receiver;

    logic       clk;
    logic       reset;
    logic       baud_enable;
    logic       rxd;
    logic       rd_ack;
    logic [7:0] data;
    logic       rda;
    logic       framing_err;
    logic       overrun_err;

    int passed;
    int total;
    int cyc;
    int fall_cyc;
    int rise_cyc;
    int lat;
    logic rda_q;

    uart_receiver #(.OVERSAMPLE(16), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_enable (baud_enable),
        .rxd         (rxd),
        .rd_ack      (rd_ack),
        .data        (data),
        .rda         (rda),
        .framing_err (framing_err),
        .overrun_err (overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        rda_q    = 1'b0;
        rise_cyc = 0;
    end
    always @(negedge clk) begin
        if (rda && !rda_q) rise_cyc = cyc;
        rda_q = rda;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ack_at > 0 pulses rd_ack on the clk that is ack_at+1 clk into the stop bit
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int ack_at);
        logic [7:0] v;
        v   = b;
        rxd = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rxd = v[i];
            tick(16);
        end
        rxd = stop_bit;
        if (ack_at > 0) begin
            tick(ack_at);
            rd_ack = 1'b1;
            tick(1);
            rd_ack = 1'b0;
            tick(15 - ack_at);
        end else begin
            tick(16);
        end
    endtask

    task automatic ack_pulse();
        rd_ack = 1'b1;
        tick(1);
        rd_ack = 1'b0;
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        reset       = 1'b0;
        baud_enable = 1'b1;
        rxd         = 1'b1;
        rd_ack      = 1'b0;
        tick(3);
        check("reset_data", 32'(data), 32'h00);
        check("reset_rda", 32'(rda), 32'h0);
        check("reset_fe", 32'(framing_err), 32'h0);
        check("reset_oe", 32'(overrun_err), 32'h0);
        reset = 1'b1;
        tick(4);

        // 1: good frame A5 and rda latency
        rise_cyc = 0;
        fall_cyc = cyc;
        send_frame(8'hA5, 1'b1, 0);
        check("t1_rda", 32'(rda), 32'h1);
        check("t1_data", 32'(data), 32'hA5);
        check("t1_fe", 32'(framing_err), 32'h0);
        check("t1_oe", 32'(overrun_err), 32'h0);
        lat = rise_cyc - fall_cyc;
        check("t1_latency_in_154_156", 32'(lat >= 154 && lat <= 156), 32'h1);
        ack_pulse();
        check("t1_ack_rda", 32'(rda), 32'h0);
        check("t1_ack_data_held", 32'(data), 32'hA5);

        // 2: 4-clk glitch is rejected, then 3C received
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(20);
        check("t2_glitch_rda", 32'(rda), 32'h0);
        check("t2_glitch_fe", 32'(framing_err), 32'h0);
        check("t2_glitch_data", 32'(data), 32'hA5);
        send_frame(8'h3C, 1'b1, 0);
        check("t2_rda", 32'(rda), 32'h1);
        check("t2_data", 32'(data), 32'h3C);
        check("t2_fe", 32'(framing_err), 32'h0);
        ack_pulse();
        check("t2_ack_rda", 32'(rda), 32'h0);

        // 3: framing error with held-low line, then 0F
        send_frame(8'h55, 1'b0, 0);
        check("t3_fe", 32'(framing_err), 32'h1);
        check("t3_rda", 32'(rda), 32'h0);
        check("t3_data", 32'(data), 32'h3C);
        tick(40);
        check("t3_low_fe", 32'(framing_err), 32'h1);
        check("t3_low_rda", 32'(rda), 32'h0);
        check("t3_low_data", 32'(data), 32'h3C);
        rxd = 1'b1;
        tick(16);
        send_frame(8'h0F, 1'b1, 0);
        check("t3_good_rda", 32'(rda), 32'h1);
        check("t3_good_data", 32'(data), 32'h0F);
        check("t3_fe_sticky", 32'(framing_err), 32'h1);
        ack_pulse();
        check("t3_ack_fe", 32'(framing_err), 32'h0);
        check("t3_ack_rda", 32'(rda), 32'h0);

        // 4: overrun on back-to-back frames
        send_frame(8'h11, 1'b1, 0);
        check("t4_first_data", 32'(data), 32'h11);
        check("t4_first_oe", 32'(overrun_err), 32'h0);
        send_frame(8'h22, 1'b1, 0);
        check("t4_data", 32'(data), 32'h22);
        check("t4_rda", 32'(rda), 32'h1);
        check("t4_oe", 32'(overrun_err), 32'h1);
        ack_pulse();
        check("t4_ack_rda", 32'(rda), 32'h0);
        check("t4_ack_oe", 32'(overrun_err), 32'h0);
        check("t4_ack_fe", 32'(framing_err), 32'h0);

        // 5: rd_ack on the exact load clk of the second frame
        send_frame(8'h44, 1'b1, 0);
        check("t5_first_rda", 32'(rda), 32'h1);
        send_frame(8'h99, 1'b1, 10);
        check("t5_rda", 32'(rda), 32'h1);
        check("t5_data", 32'(data), 32'h99);
        check("t5_oe", 32'(overrun_err), 32'h0);

        // 6: async reset during data bit 4 (rda still 1 from test 5)
        rxd = 1'b0;
        tick(16);
        rxd = 1'b0; tick(16);
        rxd = 1'b1; tick(16);
        rxd = 1'b0; tick(16);
        rxd = 1'b1; tick(16);
        rxd = 1'b1; tick(8);
        check("t6_pre_rda", 32'(rda), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_data", 32'(data), 32'h00);
        check("t6_rst_rda", 32'(rda), 32'h0);
        check("t6_rst_fe", 32'(framing_err), 32'h0);
        check("t6_rst_oe", 32'(overrun_err), 32'h0);
        rxd = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(40);
        check("t6_after_rda", 32'(rda), 32'h0);
        check("t6_after_fe", 32'(framing_err), 32'h0);
        send_frame(8'hFF, 1'b1, 0);
        check("t6_rda", 32'(rda), 32'h1);
        check("t6_data", 32'(data), 32'hFF);
        check("t6_fe", 32'(framing_err), 32'h0);
        check("t6_oe", 32'(overrun_err), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
